// File: rtl/steer_pkg.sv
// Shared types, command limits and the saturating clamp helper for the
// steering PI controller.
package steer_pkg;

  // Controller sequence; busy is simply "not IDLE".
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CALC_P = 3'd1,
    CALC_I = 3'd2,
    SUM    = 3'd3,
    DRIVE  = 3'd4
  } state_t;

  // Symmetric command range: -1024 is excluded because the motor stage
  // takes a 10-bit magnitude of the command.
  localparam int CMD_MAX = 1023;
  localparam int CMD_MIN = -1023;

  // Working width of the clamp helper; every clamp point fits inside it.
  localparam int CLAMP_W = 32;

  // Largest magnitude of a symmetric signed range of width w.
  function automatic int sym_max(input int w);
    return (1 <<< (w - 1)) - 1;
  endfunction

  // Saturate x into [lo, hi].
  function automatic logic signed [CLAMP_W-1:0] sat_val(
    input logic signed [CLAMP_W-1:0] x,
    input logic signed [CLAMP_W-1:0] lo,
    input logic signed [CLAMP_W-1:0] hi
  );
    if (x < lo) return lo;
    if (x > hi) return hi;
    return x;
  endfunction

endpackage

// File: rtl/sat_clamp.sv
// Combinational signed saturating clamp from IN_W to OUT_W bits.
// The limits must be representable in OUT_W bits.
module sat_clamp
  import steer_pkg::*;
#(
  parameter int IN_W  = 12,
  parameter int OUT_W = 11,
  parameter int MIN_V = CMD_MIN,
  parameter int MAX_V = CMD_MAX
) (
  input  logic signed [IN_W-1:0]  din,
  output logic signed [OUT_W-1:0] dout
);

  logic signed [CLAMP_W-1:0] wide;

  // Sign-extend, saturate, then narrow (narrowing is lossless after the clamp).
  always_comb begin
    wide = sat_val(CLAMP_W'(din), MIN_V, MAX_V);
    dout = OUT_W'(wide);
  end

endmodule

// File: rtl/steer_pi.sv
// Steering PI controller: one error sample in, one pair of saturated
// left/right drive commands out, four cycles later. Each stage result is
// registered on entry to the state named for it, so P is valid in CALC_P,
// the integrator in CALC_I, the correction in SUM and the commands in DRIVE.
module steer_pi
  import steer_pkg::*;
#(
  parameter logic [3:0] P_COEF  = 4'd3,
  parameter int         I_SHIFT = 4,
  parameter int         INT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               go,
  input  logic signed [11:0] err,
  input  logic               err_vld,
  input  logic signed [10:0] base_spd,
  output logic signed [10:0] lft,
  output logic signed [10:0] rht,
  output logic               out_vld,
  output logic               busy
);

  localparam int P_W   = 16;
  localparam int SUM_W = ((INT_W > P_W) ? INT_W : P_W) + 1;

  state_t                  state_q, state_d;
  logic signed [10:0]      err_sat_q, err_sat_d;
  logic signed [10:0]      base_q, base_d;
  logic signed [P_W-1:0]   p_q, p_d;
  logic signed [INT_W-1:0] integ_q, integ_d;
  logic signed [10:0]      corr_q, corr_d;
  logic signed [10:0]      lft_q, lft_d;
  logic signed [10:0]      rht_q, rht_d;
  logic                    out_vld_q, out_vld_d;

  // Full-width intermediates feeding the clamps.
  logic signed [10:0]      err_c, base_c, corr_c, lft_c, rht_c;
  logic signed [INT_W-1:0] integ_c;
  logic signed [P_W-1:0]   p_c;
  logic signed [INT_W:0]   integ_sum;
  logic signed [SUM_W-1:0] corr_sum;
  logic signed [11:0]      lft_sum, rht_sum;

  assign p_c       = P_W'(err_c) * $signed({{(P_W-4){1'b0}}, P_COEF});
  assign integ_sum = (INT_W+1)'(integ_q) + (INT_W+1)'(err_sat_q);
  assign corr_sum  = SUM_W'(p_q) + SUM_W'(integ_q >>> I_SHIFT);
  assign lft_sum   = 12'(base_q) + 12'(corr_q);
  assign rht_sum   = 12'(base_q) - 12'(corr_q);

  sat_clamp #(.IN_W(12), .OUT_W(11)) u_clamp_err (.din(err), .dout(err_c));
  sat_clamp #(.IN_W(11), .OUT_W(11)) u_clamp_base (.din(base_spd), .dout(base_c));
  sat_clamp #(
    .IN_W (INT_W + 1),
    .OUT_W(INT_W),
    .MIN_V(-sym_max(INT_W)),
    .MAX_V(sym_max(INT_W))
  ) u_clamp_integ (.din(integ_sum), .dout(integ_c));
  sat_clamp #(.IN_W(SUM_W), .OUT_W(11)) u_clamp_corr (.din(corr_sum), .dout(corr_c));
  sat_clamp #(.IN_W(12), .OUT_W(11)) u_clamp_lft (.din(lft_sum), .dout(lft_c));
  sat_clamp #(.IN_W(12), .OUT_W(11)) u_clamp_rht (.din(rht_sum), .dout(rht_c));

  // Next-state and datapath update; go low overrides everything and brakes.
  always_comb begin
    state_d   = state_q;
    err_sat_d = err_sat_q;
    base_d    = base_q;
    p_d       = p_q;
    integ_d   = integ_q;
    corr_d    = corr_q;
    lft_d     = lft_q;
    rht_d     = rht_q;
    out_vld_d = 1'b0;
    if (!go) begin
      state_d = IDLE;
      integ_d = '0;
      lft_d   = '0;
      rht_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (err_vld) begin
            err_sat_d = err_c;
            base_d    = base_c;
            p_d       = p_c;
            state_d   = CALC_P;
          end
        end
        CALC_P: begin
          integ_d = integ_c;
          state_d = CALC_I;
        end
        CALC_I: begin
          corr_d  = corr_c;
          state_d = SUM;
        end
        SUM: begin
          lft_d     = lft_c;
          rht_d     = rht_c;
          out_vld_d = 1'b1;
          state_d   = DRIVE;
        end
        DRIVE:   state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      err_sat_q <= '0;
      base_q    <= '0;
      p_q       <= '0;
      integ_q   <= '0;
      corr_q    <= '0;
      lft_q     <= '0;
      rht_q     <= '0;
      out_vld_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      err_sat_q <= err_sat_d;
      base_q    <= base_d;
      p_q       <= p_d;
      integ_q   <= integ_d;
      corr_q    <= corr_d;
      lft_q     <= lft_d;
      rht_q     <= rht_d;
      out_vld_q <= out_vld_d;
    end
  end

  assign lft     = lft_q;
  assign rht     = rht_q;
  assign out_vld = out_vld_q;
  assign busy    = (state_q != IDLE);

endmodule
